// File: rtl/vga_frame_reader_if.sv
// Frame-buffer read port plus VGA connector pins for the display-side reader.
// The master is the reader; the slave is the frame-buffer and connector side.
interface vga_frame_reader_if;
   logic [16:0] addr_out;
   logic        regread;
   logic [15:0] data_in;
   logic [3:0]  VGA_R;
   logic [3:0]  VGA_G;
   logic [3:0]  VGA_B;
   logic        VGA_Hsync_n;
   logic        VGA_Vsync_n;
   logic        frame_start;

   modport master (
      output addr_out, regread,
      output VGA_R, VGA_G, VGA_B, VGA_Hsync_n, VGA_Vsync_n, frame_start,
      input  data_in
   );

   modport slave (
      input  addr_out, regread,
      input  VGA_R, VGA_G, VGA_B, VGA_Hsync_n, VGA_Vsync_n, frame_start,
      output data_in
   );
endinterface

// File: rtl/vga_frame_reader.sv
// 640x480 VGA timing + frame-buffer readout; define SCALE2X_EN for 2x pixel doubling.
// Counter position reaches colour/sync pins 3 clocks later; free-running, no backpressure.
module vga_frame_reader #(
   parameter int IMG_W  = 160,
   parameter int IMG_H  = 120,
   parameter int H_VIS  = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_VIS  = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33
) (
   input  logic               clk,
   input  logic               RESET,
   vga_frame_reader_if.master bus
);
   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

   logic [16:0] w_col;
   logic        w_base_step;
   logic [9:0]  r_h_cnt;
   logic [9:0]  r_v_cnt;

`ifdef SCALE2X_EN
   localparam int SC = 1;
   // Each stored line serves two display lines, so advance the base after odd lines only.
   assign w_col       = 17'(r_h_cnt[9:1]);
   assign w_base_step = r_v_cnt[0];
`else
   localparam int SC = 0;
   assign w_col       = 17'(r_h_cnt);
   assign w_base_step = 1'b1;
`endif

   localparam logic [9:0]  C_H_LAST    = 10'(H_TOT - 1);
   localparam logic [9:0]  C_V_LAST    = 10'(V_TOT - 1);
   localparam logic [9:0]  C_H_VIS     = 10'(H_VIS);
   localparam logic [9:0]  C_V_VIS     = 10'(V_VIS);
   localparam logic [9:0]  C_IMG_H     = 10'(IMG_W << SC);
   localparam logic [9:0]  C_IMG_V     = 10'(IMG_H << SC);
   localparam logic [9:0]  C_HS_BEG    = 10'(H_VIS + H_FP);
   localparam logic [9:0]  C_HS_END    = 10'(H_VIS + H_FP + H_SYNC);
   localparam logic [9:0]  C_VS_BEG    = 10'(V_VIS + V_FP);
   localparam logic [9:0]  C_VS_END    = 10'(V_VIS + V_FP + V_SYNC);
   localparam logic [16:0] C_LINE_STEP = 17'(IMG_W);

   logic [16:0] r_line_base;
   logic        r_pix2, r_hs2, r_vs2, r_fs2;
   logic        r_pix3, r_hs3, r_vs3, r_fs3;
   logic        w_h_last, w_v_last, w_vis, w_img, w_hs, w_vs, w_fs;

   assign w_h_last = (r_h_cnt == C_H_LAST);
   assign w_v_last = (r_v_cnt == C_V_LAST);
   assign w_vis    = (r_h_cnt < C_H_VIS) && (r_v_cnt < C_V_VIS);
   assign w_img    = (r_h_cnt < C_IMG_H) && (r_v_cnt < C_IMG_V);
   // Sync flags are carried active-high through the pipe so a cleared pipe means "no pulse".
   assign w_hs     = (r_h_cnt >= C_HS_BEG) && (r_h_cnt < C_HS_END);
   assign w_vs     = (r_v_cnt >= C_VS_BEG) && (r_v_cnt < C_VS_END);
   assign w_fs     = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);

   always_ff @(posedge clk) begin
      if (RESET) begin
         r_h_cnt         <= '0;
         r_v_cnt         <= '0;
         r_line_base     <= '0;
         r_pix2          <= 1'b0;
         r_hs2           <= 1'b0;
         r_vs2           <= 1'b0;
         r_fs2           <= 1'b0;
         r_pix3          <= 1'b0;
         r_hs3           <= 1'b0;
         r_vs3           <= 1'b0;
         r_fs3           <= 1'b0;
         bus.addr_out    <= '0;
         bus.regread     <= 1'b0;
         bus.VGA_R       <= '0;
         bus.VGA_G       <= '0;
         bus.VGA_B       <= '0;
         bus.VGA_Hsync_n <= 1'b1;
         bus.VGA_Vsync_n <= 1'b1;
         bus.frame_start <= 1'b0;
      end else begin
         if (w_h_last) begin
            r_h_cnt <= '0;
            if (w_v_last) begin
               r_v_cnt     <= '0;
               r_line_base <= '0;
            end else begin
               r_v_cnt <= r_v_cnt + 10'd1;
               if (w_base_step) r_line_base <= r_line_base + C_LINE_STEP;
            end
         end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
         end

         if (w_img) bus.addr_out <= r_line_base + w_col;
         bus.regread <= w_img;
         r_pix2      <= w_vis && w_img;
         r_hs2       <= w_hs;
         r_vs2       <= w_vs;
         r_fs2       <= w_fs;

         r_pix3 <= r_pix2;
         r_hs3  <= r_hs2;
         r_vs3  <= r_vs2;
         r_fs3  <= r_fs2;

         bus.VGA_R       <= r_pix3 ? bus.data_in[15:12] : 4'd0;
         bus.VGA_G       <= r_pix3 ? bus.data_in[10:7]  : 4'd0;
         bus.VGA_B       <= r_pix3 ? bus.data_in[4:1]   : 4'd0;
         bus.VGA_Hsync_n <= !r_hs3;
         bus.VGA_Vsync_n <= !r_vs3;
         bus.frame_start <= r_fs3;
      end
   end
endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench: full-size reader checked cycle by cycle for the first lines and a mid-line reset;
// a reduced-timing instance covers whole-frame sync, frame_start and read-count behaviour.
module tb_vga_frame_reader;
   logic clk   = 1'b0;
   logic RESET = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

`ifdef SCALE2X_EN
   localparam int S        = 1;
   localparam int E_RD_L0  = 320;
   localparam int E_A161   = 80;
   localparam int E_RD161  = 1;
   localparam int E_A801   = 0;
   localparam int E_RD_F1  = 128;
`else
   localparam int S        = 0;
   localparam int E_RD_L0  = 160;
   localparam int E_A161   = 159;
   localparam int E_RD161  = 0;
   localparam int E_A801   = 160;
   localparam int E_RD_F1  = 32;
`endif

   vga_frame_reader_if b0();
   vga_frame_reader_if b1();

   vga_frame_reader u0 (.clk(clk), .RESET(RESET), .bus(b0));

   vga_frame_reader #(
      .IMG_W(8), .IMG_H(4),
      .H_VIS(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_VIS(8),  .V_FP(1), .V_SYNC(2), .V_BP(1)
   ) u1 (.clk(clk), .RESET(RESET), .bus(b1));

   always #20 clk = ~clk;

   function automatic logic [15:0] pat(input logic [16:0] a);
      case (int'(a) % 3)
         0:       return 16'hF800;
         1:       return 16'h07E0;
         default: return 16'h001F;
      endcase
   endfunction

   function automatic logic [11:0] rgb_of(input int a);
      case (a % 3)
         0:       return 12'hF00;
         1:       return 12'h0F0;
         default: return 12'h00F;
      endcase
   endfunction

   // Synchronous frame-buffer models; out-of-image cycles return all ones to expose leaks.
   always @(posedge clk) begin
      b0.data_in <= b0.regread ? pat(b0.addr_out) : 16'hFFFF;
      b1.data_in <= b1.regread ? pat(b1.addr_out) : 16'hFFFF;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   int last_addr0 = 0;

   // t = number of rising edges since reset was released, sampled on the falling edge.
   task automatic check_u0(input int t);
      int p, q, h, v;
      logic rd, hs, vs, fs;
      logic [11:0] rgb;
      p  = t - 1;
      rd = 1'b0;
      if (p >= 0) begin
         h = p % 800;
         v = (p / 800) % 525;
         if (h < (160 << S) && v < (120 << S)) begin
            rd = 1'b1;
            last_addr0 = (v >> S) * 160 + (h >> S);
         end
      end
      check($sformatf("regread@%0d", t), 32'(b0.regread), 32'(rd));
      check($sformatf("addr@%0d", t), 32'(b0.addr_out), last_addr0);
      q   = t - 3;
      rgb = 12'h000;
      hs  = 1'b1;
      vs  = 1'b1;
      fs  = 1'b0;
      if (q >= 0) begin
         h = q % 800;
         v = (q / 800) % 525;
         if (h < 640 && v < 480 && h < (160 << S) && v < (120 << S))
            rgb = rgb_of((v >> S) * 160 + (h >> S));
         hs = !(h >= 656 && h < 752);
         vs = !(v >= 490 && v < 492);
         fs = (h == 0 && v == 0);
      end
      check($sformatf("rgb@%0d", t), 32'({b0.VGA_R, b0.VGA_G, b0.VGA_B}), 32'(rgb));
      check($sformatf("hsync_n@%0d", t), 32'(b0.VGA_Hsync_n), 32'(hs));
      check($sformatf("vsync_n@%0d", t), 32'(b0.VGA_Vsync_n), 32'(vs));
      check($sformatf("frame_start@%0d", t), 32'(b0.frame_start), 32'(fs));
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_rgb"},     32'({b0.VGA_R, b0.VGA_G, b0.VGA_B}), 32'h0);
      check({tag, "_hsync_n"}, 32'(b0.VGA_Hsync_n), 32'h1);
      check({tag, "_vsync_n"}, 32'(b0.VGA_Vsync_n), 32'h1);
      check({tag, "_regread"}, 32'(b0.regread), 32'h0);
      check({tag, "_addr"},    32'(b0.addr_out), 32'h0);
      check({tag, "_fs"},      32'(b0.frame_start), 32'h0);
   endtask

   initial begin
      int rd0, fs1_a, fs1_b, hs_fall1, vs_fall1, vs_low1, hs_low1, rd1, last_rd1;
      rd0 = 0; fs1_a = -1; fs1_b = -1; hs_fall1 = -1; vs_fall1 = -1;
      vs_low1 = 0; hs_low1 = 0; rd1 = 0; last_rd1 = -1;

      RESET = 1'b1;
      repeat (5) @(negedge clk);
      check_idle("reset");
      RESET = 1'b0;

      for (int t = 1; t <= 1900; t++) begin
         @(negedge clk);
         check_u0(t);
         if (t <= 800 && b0.regread) rd0++;
         if (t == 3)   check("first_fs", 32'(b0.frame_start), 32'h1);
         if (t == 658) check("hs_before_fall", 32'(b0.VGA_Hsync_n), 32'h1);
         if (t == 659) check("hs_first_fall", 32'(b0.VGA_Hsync_n), 32'h0);
         if (t == 755) check("hs_first_rise", 32'(b0.VGA_Hsync_n), 32'h1);
         if (t == 161) begin
            check("addr_t161", 32'(b0.addr_out), E_A161);
            check("rd_t161", 32'(b0.regread), E_RD161);
         end
         if (t == 801) check("line1_addr", 32'(b0.addr_out), E_A801);

         if (b1.frame_start) begin
            if (fs1_a < 0) fs1_a = t;
            else if (fs1_b < 0) fs1_b = t;
         end
         if (!b1.VGA_Hsync_n && hs_fall1 < 0) hs_fall1 = t;
         if (!b1.VGA_Vsync_n && vs_fall1 < 0) vs_fall1 = t;
         if (t >= 3 && t <= 290) begin
            if (!b1.VGA_Vsync_n) vs_low1++;
            if (!b1.VGA_Hsync_n) hs_low1++;
         end
         if (t >= 1 && t <= 288 && b1.regread) begin
            rd1++;
            last_rd1 = int'(b1.addr_out);
         end
      end

      check("line0_reads", rd0, E_RD_L0);
      check("small_fs_first", fs1_a, 3);
      check("small_fs_period", fs1_b, 291);
      check("small_hs_fall", hs_fall1, 21);
      check("small_vs_fall", vs_fall1, 219);
      check("small_vs_width", vs_low1, 48);
      check("small_hs_low_per_frame", hs_low1, 36);
      check("small_reads_per_frame", rd1, E_RD_F1);
      check("small_last_addr", last_rd1, 31);

      // Counter now holds h=300, v=2; one reset clock must flush the whole pipe.
      RESET = 1'b1;
      @(negedge clk);
      check_idle("midreset");
      RESET = 1'b0;
      last_addr0 = 0;
      for (int t = 1; t <= 900; t++) begin
         @(negedge clk);
         check_u0(t);
         if (t == 3) check("restart_fs", 32'(b0.frame_start), 32'h1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/vga_frame_reader.md
# vga_frame_reader

Display-side stage of the camera datapath: generates 640x480@60 Hz VGA timing from the 25 MHz pixel clock, reads the captured frame out of the dual-port frame buffer through its read port, and drives 4-bit-per-channel colour plus active-low syncs to the connector. It sits directly downstream of the frame buffer, which the camera capture stage fills through its write port. Pixels outside the stored image and outside the visible area are driven black.

## Interface
- Parameters:
- IMG_W, 160, stored image width in pixels
- IMG_H, 120, stored image height in lines; IMG_W*IMG_H ≤ 2^17
- H_VIS/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in clocks (total 800)
- V_VIS/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines (total 525)
- Ports:
- clk  in  1  pixel clock, 25 MHz; all logic on the rising edge
- RESET  in  1  synchronous, active-high reset
- data_in  in  16  frame-buffer read data, RGB565; valid one clock after addr_out is sampled
- addr_out  out  17  frame-buffer read address
- regread  out  1  frame-buffer read enable
- VGA_R, VGA_G, VGA_B  out  4 each  colour outputs
- VGA_Hsync_n, VGA_Vsync_n  out  1 each  active-low syncs
- frame_start  out  1  one-clock pulse when the output pixel is (0,0)

## Operation
- Counters: h_cnt 0..799, wraps to 0 and increments v_cnt; v_cnt 0..524, wraps to 0.
- Visible: h_cnt<640 and v_cnt<480. Hsync low for 656≤h_cnt<752; Vsync low for 490≤v_cnt<492.
- In-image (no scaling): h_cnt<IMG_W and v_cnt<IMG_H; address = v_cnt*IMG_W + h_cnt. No multiplier required; a line-base register plus column counter is the intended structure.
- regread = 1 only for in-image positions; addr_out holds its last value otherwise.
- Colour mapping: R = data_in[15:12], G = data_in[10:7], B = data_in[4:1].
- Colour = 0 whenever the position is not in-image or not visible.
- Pipeline, aligned per pixel: stage 1 counters; stage 2 addr_out/regread registered, position flags delayed; stage 3 RAM access; stage 4 colour and syncs registered.
- Reset: h_cnt=v_cnt=0; addr_out=0; regread=0; colour=0; VGA_Hsync_n=VGA_Vsync_n=1; frame_start=0; all pipeline flags cleared.
- Reset mid-frame: all pipeline contents are discarded. The counters restart at (0,0) on the first clock with RESET low. No partial pixel or sync pulse from before reset appears at the outputs.

## Timing
- Latency: counter position (h,v) reaches the colour and sync outputs 3 clocks after the counter holds it. Sync and colour for the same position change on the same edge.
- addr_out/regread for (h,v) are valid 1 clock after the counter holds (h,v).
- Line period 800 clocks; frame period 420000 clocks; Hsync width 96 clocks; Vsync width 1600 clocks.
- frame_start is high for exactly one clock per frame, coincident with pixel (0,0) at the outputs.
- The first frame after reset has the same timing as steady state, offset by the 3-clock latency.

## Configuration
- SCALE2X_EN defined: pixel doubling. Image position (h,v) maps to stored pixel (h>>1, v>>1). In-image region is 2*IMG_W x 2*IMG_H. Each address is issued on 2 consecutive clocks and each stored line is read on 2 consecutive display lines.
- SCALE2X_EN undefined: 1:1 mapping as in Operation. Timing and latency are identical in both builds.

## Test plan
- Reset: hold RESET 5 clocks → colour 0, both syncs 1, regread 0, addr_out 0, frame_start 0. Release → first Hsync falling edge 659 clocks later (656+3).
- Sync timing over 2 frames → Hsync period 800 clocks, low 96. Vsync period 420000, low 1600. frame_start spacing 420000.
- Address sequence, 1:1 → line 0 reads 0..159 consecutively, line 1 starts at 160, last read 19199. Exactly 19200 regread cycles per frame.
- Colour: RAM model returns 16'hF800, then 16'h07E0, then 16'h001F → outputs (F,0,0), (0,F,0), (0,0,F) respectively. Pixels at h=160..639 and all lines ≥120 are 0. Blanking is 0 even with data_in=16'hFFFF.
- SCALE2X_EN build → addr_out sequence 0,0,1,1,…,159,159 on display lines 0 and 1, then 160,160,… on line 2. 76800 regread cycles per frame; in-image region is 320x240.
- Assert RESET for 1 clock at h=300, v=200 → next output is black with syncs high. Counters restart at (0,0), and the next frame_start occurs 3 clocks after release.
